// File: rtl/adder_result_checker.sv
// Response checker for the 16-bit ripple-carry adder: accepts an operand set, waits for the
// adder to settle, samples {cout, s}, compares against a + b + cin and keeps statistics.
module adder_result_checker #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] s,
  input  logic             cout,
  input  logic             stop_on_fail,
  output logic             done_valid,
  output logic             done_pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic             first_fail_cin,
  output logic [WIDTH:0]   first_fail_obs,
  output logic             halted
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    HALT
  } state_t;

  state_t          state;
  logic [SC_W-1:0] settle_cnt;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             cin_p0;
  logic [WIDTH:0]   obs_p1;
  logic             match_p1;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Unsigned WIDTH+1-bit reference sum; the carry lands in the MSB.
  function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  assign match_p1 = (golden_sum(a_p0, b_p0, cin_p0) == obs_p1);

  always_ff @(posedge clk) begin
    done_valid <= 1'b0;
    if (rst) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      in_ready         <= 1'b1;
      done_pass        <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
      first_fail_cin   <= 1'b0;
      first_fail_obs   <= '0;
      halted           <= 1'b0;
    end else begin
      case (state)
        // Stage p0: operand acceptance
        IDLE: begin
          if (in_valid && in_ready) begin
            a_p0       <= a;
            b_p0       <= b;
            cin_p0     <= cin;
            settle_cnt <= SC_LOAD;
            in_ready   <= 1'b0;
            state      <= SETTLE;
          end
        end
        // Stage p1: sample the adder output once the counter runs out
        SETTLE: begin
          settle_cnt <= settle_cnt - SC_W'(1);
          if (settle_cnt == SC_W'(1)) begin
            obs_p1 <= {cout, s};
            state  <= CHECK;
          end
        end
        // Stage p2: compare, statistics and first-failure snapshot
        CHECK: begin
          done_valid <= 1'b1;
          done_pass  <= match_p1;
          if (match_p1) begin
            pass_count <= sat_inc(pass_count);
          end else begin
            fail_count <= sat_inc(fail_count);
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_a     <= a_p0;
              first_fail_b     <= b_p0;
              first_fail_cin   <= cin_p0;
              first_fail_obs   <= obs_p1;
            end
          end
          if (!match_p1 && stop_on_fail) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        HALT: begin
          in_ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_result_checker.md
# adder_result_checker

Clocked response checker that sits on the output side of the 16-bit ripple-carry adder. It accepts one operand set per transaction and holds it while the combinational adder settles. It then samples the adder's sum and carry-out, compares them against a golden `a + b + cin`, and keeps pass/fail statistics plus a snapshot of the first failing vector. It pairs with the stimulus generator as the receiving end of the adder test interface.

## Interface
- `WIDTH`, 16: operand/sum width.
- `SETTLE_CYCLES`, 4: clock cycles to wait between operand acceptance and sampling `s`/`cout`; legal range ≥1.
- `CNT_W`, 16: width of the pass/fail counters.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand set `a`/`b`/`cin` is presented.
- `in_ready`  out  1  checker can accept an operand set.
- `a`, `b`  in  WIDTH  operands, the same values driven into the adder.
- `cin`  in  1  carry-in driven into the adder.
- `s`  in  WIDTH  adder sum.
- `cout`  in  1  adder carry-out.
- `stop_on_fail`  in  1  when set, the first mismatch halts the checker.
- `done_valid`  out  1  one-cycle pulse: a check completed.
- `done_pass`  out  1  result of that check; meaningful only while `done_valid` is 1.
- `pass_count`, `fail_count`  out  CNT_W  saturating totals.
- `first_fail_valid`  out  1  sticky; a first failure has been captured.
- `first_fail_a`, `first_fail_b`  out  WIDTH  operands of the first failure.
- `first_fail_cin`  out  1  carry-in of the first failure.
- `first_fail_obs`  out  WIDTH+1  `{cout, s}` observed at the first failure.
- `halted`  out  1  checker is stopped after a failure.

## Operation
- Four states: IDLE, SETTLE, CHECK, HALT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, register `a`, `b`, `cin`, load the settle counter with `SETTLE_CYCLES`, and go to SETTLE.
- **SETTLE**
  - `in_ready`=0.
  - The counter decrements each cycle.
  - When it reaches 0, register `{cout, s}` and go to CHECK.
  - The stimulus side must hold `a`/`b`/`cin` stable on the adder while `in_ready`=0. The checker never re-reads these inputs after acceptance.
- **CHECK**
  - `in_ready`=0.
  - Golden value is `{1'b0,a_reg} + {1'b0,b_reg} + cin_reg`, WIDTH+1 bits, unsigned; the carry lands in the MSB.
  - Compare the golden value against the registered `{cout, s}` and pulse `done_valid` with `done_pass` set to the compare result.
  - On a pass, increment `pass_count`; on a fail, increment `fail_count`. Both counters saturate at 2^CNT_W−1 with no wrap.
  - On a fail while `first_fail_valid`=0, capture the operands and the observed value, then set `first_fail_valid`. Later failures never overwrite the snapshot.
  - Next state: HALT if the check failed and `stop_on_fail`=1; otherwise IDLE.
- **HALT**
  - `in_ready`=0 and `halted`=1.
  - `in_valid` is ignored.
  - Only `rst` exits this state.
- `stop_on_fail` is sampled in CHECK only.
- **Reset values:** state IDLE; `in_ready`=1 in the cycle after the reset edge. All of the following are 0: `done_valid`, `done_pass`, both counters, `first_fail_*` (all fields), `halted`.
- **Reset mid-transaction** (during SETTLE or CHECK): the in-flight check is discarded, no `done_valid` pulse is produced, and no counter changes.

## Timing
- Accept edge = E0.
- `{cout, s}` is sampled at edge E(SETTLE_CYCLES).
- The compare and all updates occur at edge E(SETTLE_CYCLES+1). `done_valid`, the counters and the snapshot become visible in the cycle following that edge.
- `in_ready` returns to 1 in that same cycle, unless the checker halted.
- The next accept can occur at E(SETTLE_CYCLES+2) at the earliest, giving a throughput of one check per SETTLE_CYCLES+2 cycles.
- `done_valid` is high for exactly one cycle per check.
- All outputs are registered; there are no combinational paths from any input to any output.

## Test plan
1. **Basic pass:** `SETTLE_CYCLES`=4; accept `a`=0x0001, `b`=0x0001, `cin`=0 with the adder returning `s`=0x0002, `cout`=0.
   - Required: `done_valid` pulses for exactly one cycle, in the cycle after E5 (one cycle after the sample at E4).
   - Required: `done_pass`=1, `pass_count`=1, `fail_count`=0, `in_ready`=1 in that same cycle.
2. **Overflow carry:** `a`=0xFFFF, `b`=0x0001, `cin`=1; observed `s`=0x0001, `cout`=1.
   - Required: pass, `pass_count` increments.
   - Repeat with `cout` forced to 0. Required: fail, `fail_count`=1.
3. **First-failure snapshot:** inject `a`=0x1234, `b`=0x1111, `cin`=0 with observed `s`=0x2346 (golden 0x02345).
   - Required: `first_fail_valid`=1, `first_fail_obs`=0x02346.
   - Then inject a second mismatch with `a`=0x0002. Required: the snapshot still holds `a`=0x1234, and `fail_count`=2.
4. **Halt on fail:** `stop_on_fail`=1 and a mismatch is checked.
   - Required: `halted`=1 and `in_ready`=0 for 20 cycles while `in_valid`=1; no further `done_valid` pulses.
   - Then assert `rst`. Required: all outputs return to their reset values.
5. **Reset mid-SETTLE:** assert `rst` two cycles after accept.
   - Required: no `done_valid` pulse, both counters stay 0, `in_ready`=1 in the cycle after the reset edge.
6. **Saturation:** `CNT_W`=2; run 5 consecutive passes.
   - Required: `pass_count` reads 3 after the 3rd, 4th and 5th checks, and `done_valid` still pulses each time.
